// File: rtl/mul_div_unit_pkg.sv
// ---------------------------------------------------------------------------
// mul_div_unit_pkg
// Shared encodings for the EX-stage multiply/divide unit: operation codes,
// FSM state encodings, the default operand width and two small helpers that
// decode an operation into "is a divide" and "is signed".
// ---------------------------------------------------------------------------
package mul_div_unit_pkg;

   // Default operand width; hi/lo are each this wide.
   localparam int MD_WIDTH = 32;

   // Operation encodings as presented on the op port.
   localparam logic [1:0] MD_OP_MULT  = 2'b00;
   localparam logic [1:0] MD_OP_MULTU = 2'b01;
   localparam logic [1:0] MD_OP_DIV   = 2'b10;
   localparam logic [1:0] MD_OP_DIVU  = 2'b11;

   // Control FSM states.
   typedef enum logic [1:0] {
      MD_STATE_IDLE = 2'd0,
      MD_STATE_CALC = 2'd1,
      MD_STATE_FIX  = 2'd2,
      MD_STATE_DONE = 2'd3
   } md_state_t;

   // True for DIV and DIVU.
   function automatic logic md_is_div(input logic [1:0] op);
      return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
   endfunction

   // True for the two's-complement operations MULT and DIV.
   function automatic logic md_is_signed(input logic [1:0] op);
      return (op == MD_OP_MULT) || (op == MD_OP_DIV);
   endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// ---------------------------------------------------------------------------
// mul_div_unit_if
// Request/response bundle between the EX stage and the multiply/divide unit.
//   start, op, operand_1, operand_2, flush : request side (EX stage drives)
//   busy, done, hi, lo, div_by_zero        : response side (unit drives)
// Modports:
//   master - the pipeline / testbench side
//   slave  - the mul_div_unit side
// ---------------------------------------------------------------------------
interface mul_div_unit_if
   import mul_div_unit_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) ();

   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] operand_1;
   logic [WIDTH-1:0] operand_2;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_by_zero;

   modport master (
      output start, op, operand_1, operand_2, flush,
      input  busy, done, hi, lo, div_by_zero
   );

   modport slave (
      input  start, op, operand_1, operand_2, flush,
      output busy, done, hi, lo, div_by_zero
   );

endinterface

// File: rtl/mul_div_unit_negate.sv
// ---------------------------------------------------------------------------
// muldiv_negate
// Combinational conditional two's-complement negate.
//   en        : 1 -> value_out = -value_in, 0 -> value_out = value_in
//   value_in  : WIDTH-bit input
//   value_out : WIDTH-bit result (wraps modulo 2^WIDTH, so the most negative
//               value maps onto itself, which is also its correct unsigned
//               magnitude)
// ---------------------------------------------------------------------------
module muldiv_negate #(
   parameter int WIDTH = 32
) (
   input  logic             en,
   input  logic [WIDTH-1:0] value_in,
   output logic [WIDTH-1:0] value_out
);

   assign value_out = en ? ((~value_in) + WIDTH'(1)) : value_in;

endmodule

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
// Multi-cycle integer multiply/divide for the EX stage. Executes MULT, MULTU,
// DIV and DIVU on WIDTH-bit operands and returns a 2*WIDTH result as hi/lo.
// A request accepted at one clock edge produces a one-cycle done pulse
// WIDTH+2 cycles later; busy covers the iteration and sign-fix cycles so the
// pipeline can stall on it.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mul_div_unit_if.slave
//           start/op/operand_1/operand_2/flush in,
//           busy/done/hi/lo/div_by_zero out
// ---------------------------------------------------------------------------
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic           clk,
   input  logic           rst_n,
   mul_div_unit_if.slave  bus
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   md_state_t          state_q;
   md_state_t          state_d;
   logic               accept;

   logic [CNT_W-1:0]   cnt_q;
   logic               is_div_q;
   logic               neg_res_q;
   logic               neg_rem_q;
   logic               dbz_q;
   logic [WIDTH-1:0]   opb_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH:0]     rem_q;

   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               dbz_out_q;

   logic               op_signed;
   logic [WIDTH-1:0]   mag_1;
   logic [WIDTH-1:0]   mag_2;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH+1:0]   div_shift;
   logic [WIDTH+1:0]   div_trial;
   logic               div_fits;

   logic [2*WIDTH-1:0] prod_fixed;
   logic [WIDTH-1:0]   quot_fixed;
   logic [WIDTH-1:0]   rem_fixed;

   assign op_signed = md_is_signed(bus.op);

   // Operand magnitudes: signed ops work on |operand|, unsigned ops on the
   // raw value. The signs are remembered separately and reapplied in FIX.
   muldiv_negate #(.WIDTH(WIDTH)) u_abs_1 (
      .en        (op_signed & bus.operand_1[WIDTH-1]),
      .value_in  (bus.operand_1),
      .value_out (mag_1)
   );

   muldiv_negate #(.WIDTH(WIDTH)) u_abs_2 (
      .en        (op_signed & bus.operand_2[WIDTH-1]),
      .value_in  (bus.operand_2),
      .value_out (mag_2)
   );

   // Sign correction of the finished magnitudes. The quotient is negated when
   // the operand signs differ; the remainder follows the dividend's sign.
   muldiv_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
      .en        (neg_res_q),
      .value_in  (acc_q),
      .value_out (prod_fixed)
   );

   muldiv_negate #(.WIDTH(WIDTH)) u_fix_quot (
      .en        (neg_res_q),
      .value_in  (acc_q[WIDTH-1:0]),
      .value_out (quot_fixed)
   );

   muldiv_negate #(.WIDTH(WIDTH)) u_fix_rem (
      .en        (neg_rem_q),
      .value_in  (rem_q[WIDTH-1:0]),
      .value_out (rem_fixed)
   );

   // State register. Reset abandons whatever operation was in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= MD_STATE_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. A request is only looked at in IDLE or DONE, so a
   // start raised while busy is simply dropped. flush beats everything,
   // including a simultaneous start and a FIX cycle that would otherwise
   // complete the operation.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         MD_STATE_IDLE: begin
            if (bus.start && !bus.flush) begin
               accept  = 1'b1;
               state_d = MD_STATE_CALC;
            end
         end
         MD_STATE_CALC: begin
            if (bus.flush) begin
               state_d = MD_STATE_IDLE;
            end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = MD_STATE_FIX;
            end
         end
         MD_STATE_FIX: begin
            state_d = bus.flush ? MD_STATE_IDLE : MD_STATE_DONE;
         end
         MD_STATE_DONE: begin
            if (bus.flush) begin
               state_d = MD_STATE_IDLE;
            end else if (bus.start) begin
               accept  = 1'b1;
               state_d = MD_STATE_CALC;
            end else begin
               state_d = MD_STATE_IDLE;
            end
         end
         default: state_d = MD_STATE_IDLE;
      endcase
   end

   // One iteration of each algorithm, computed from the current registers.
   // Multiply: acc_q holds {partial product, unconsumed multiplier bits};
   // when the multiplier LSB is set the multiplicand is added into the upper
   // half, and the whole accumulator shifts right with the carry.
   // Divide: restoring radix-2. The next dividend bit (MSB first) is shifted
   // into the partial remainder and a trial subtract decides the quotient
   // bit; the extra top bit makes a "did not fit" result show up as a
   // borrow in the MSB instead of wrapping into a valid-looking value.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
      div_shift = {rem_q, acc_q[WIDTH-1]};
      div_trial = div_shift - {2'b00, opb_q};
      div_fits  = ~div_trial[WIDTH+1];
   end

   // Datapath registers. On accept the operands are loaded as magnitudes:
   // for multiply the multiplier goes into the low half of the accumulator
   // (it gets consumed LSB first), for divide the dividend does (its bits
   // are consumed MSB first while quotient bits shift in from the right).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dbz_q     <= 1'b0;
         opb_q     <= '0;
         acc_q     <= '0;
         rem_q     <= '0;
      end else if (accept) begin
         cnt_q     <= '0;
         is_div_q  <= md_is_div(bus.op);
         neg_res_q <= op_signed & (bus.operand_1[WIDTH-1] ^ bus.operand_2[WIDTH-1]);
         neg_rem_q <= op_signed & bus.operand_1[WIDTH-1];
         dbz_q     <= md_is_div(bus.op) & (bus.operand_2 == '0);
         rem_q     <= '0;
         if (md_is_div(bus.op)) begin
            opb_q <= mag_2;
            acc_q <= {{WIDTH{1'b0}}, mag_1};
         end else begin
            opb_q <= mag_1;
            acc_q <= {{WIDTH{1'b0}}, mag_2};
         end
      end else if ((state_q == MD_STATE_CALC) && !bus.flush) begin
         cnt_q <= cnt_q + CNT_W'(1);
         if (is_div_q) begin
            rem_q <= div_fits ? div_trial[WIDTH:0] : div_shift[WIDTH:0];
            acc_q <= {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_fits};
         end else begin
            acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
         end
      end
   end

   // Result registers, written only by a FIX cycle that is not flushed, so
   // hi/lo/div_by_zero hold across flushes and idle periods.
   // Divide by zero: the restoring loop with a zero divisor yields an
   // all-ones quotient and leaves |dividend| as remainder. lo is forced to
   // all ones without sign fix; the remainder path (magnitude re-signed
   // with the dividend's sign) reproduces operand_1 exactly, including the
   // most negative value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q      <= '0;
         lo_q      <= '0;
         dbz_out_q <= 1'b0;
      end else if ((state_q == MD_STATE_FIX) && !bus.flush) begin
         if (is_div_q) begin
            hi_q      <= rem_fixed;
            lo_q      <= dbz_q ? {WIDTH{1'b1}} : quot_fixed;
            dbz_out_q <= dbz_q;
         end else begin
            hi_q      <= prod_fixed[2*WIDTH-1:WIDTH];
            lo_q      <= prod_fixed[WIDTH-1:0];
            dbz_out_q <= 1'b0;
         end
      end
   end

   assign bus.busy        = (state_q == MD_STATE_CALC) || (state_q == MD_STATE_FIX);
   assign bus.done        = (state_q == MD_STATE_DONE);
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
   assign bus.div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
// Scoreboard bench for mul_div_unit: a 32-bit instance carries the main
// directed vectors, an 8-bit instance repeats the all-ones MULTU case.
// Expected results are pushed when a request is issued; monitors pop and
// compare whenever done is presented, including the issue-to-done latency.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;
   import mul_div_unit_pkg::*;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int          issued;
      string       tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   mul_div_unit_if #(.WIDTH(32)) bus ();
   mul_div_unit_if #(.WIDTH(8))  bus8 ();

   mul_div_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   mul_div_unit #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8)
   );

   exp_t sb[$];
   exp_t sb8[$];
   exp_t mon_e;
   exp_t mon_e8;
   int   cyc = 0;
   int   n_compared = 0;
   int   n_mismatched = 0;

   // Free-running clock and cycle counter used for latency checks.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single comparison point for the whole bench.
   function automatic void checkOutput(input string name, input logic [63:0] act,
                                       input logic [63:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   // Monitor for the 32-bit unit: every done pulse must match the oldest
   // outstanding request, WIDTH+2 = 34 cycles after it was driven.
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            checkOutput("spurious_done", bus.done, 1'b0);
         end else begin
            mon_e = sb.pop_front();
            checkOutput({mon_e.tag, "_hi"}, bus.hi, mon_e.hi);
            checkOutput({mon_e.tag, "_lo"}, bus.lo, mon_e.lo);
            checkOutput({mon_e.tag, "_dbz"}, bus.div_by_zero, mon_e.dbz);
            checkOutput({mon_e.tag, "_latency"}, cyc - mon_e.issued, 34);
         end
      end
   end

   // Monitor for the 8-bit unit: latency WIDTH+2 = 10.
   always @(negedge clk) begin
      if (bus8.done === 1'b1) begin
         if (sb8.size() == 0) begin
            checkOutput("spurious_done8", bus8.done, 1'b0);
         end else begin
            mon_e8 = sb8.pop_front();
            checkOutput({mon_e8.tag, "_hi"}, bus8.hi, mon_e8.hi);
            checkOutput({mon_e8.tag, "_lo"}, bus8.lo, mon_e8.lo);
            checkOutput({mon_e8.tag, "_dbz"}, bus8.div_by_zero, mon_e8.dbz);
            checkOutput({mon_e8.tag, "_latency"}, cyc - mon_e8.issued, 10);
         end
      end
   end

   // Drives one request for a single cycle, starting at the current negedge,
   // and records the expected response. Returns at the following negedge.
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp_hi,
                                input logic [31:0] exp_lo, input logic exp_dbz,
                                input bit expect_done, input string tag);
      exp_t e;
      bus.start     = 1'b1;
      bus.op        = op;
      bus.operand_1 = a;
      bus.operand_2 = b;
      if (expect_done) begin
         e.hi     = exp_hi;
         e.lo     = exp_lo;
         e.dbz    = exp_dbz;
         e.issued = cyc;
         e.tag    = tag;
         sb.push_back(e);
      end
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Waits (bounded) for the done negedge of the 32-bit unit.
   task automatic waitDone(input string tag);
      int k;
      k = 0;
      while (bus.done !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (k >= 100) checkOutput({tag, "_timeout"}, bus.done, 1'b1);
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_busy"}, bus.busy, 1'b0);
      checkOutput({tag, "_done"}, bus.done, 1'b0);
      checkOutput({tag, "_hi"}, bus.hi, 32'h0);
      checkOutput({tag, "_lo"}, bus.lo, 32'h0);
      checkOutput({tag, "_dbz"}, bus.div_by_zero, 1'b0);
   endtask

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int k8;
      exp_t e8;
      bus.start = 1'b0;  bus.flush = 1'b0;  bus.op = MD_OP_MULT;
      bus.operand_1 = '0;  bus.operand_2 = '0;
      bus8.start = 1'b0; bus8.flush = 1'b0; bus8.op = MD_OP_MULT;
      bus8.operand_1 = '0; bus8.operand_2 = '0;

      repeat (3) @(negedge clk);
      checkReset("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Test 1: MULTU all-ones, with cycle-exact busy/done profile.
      applyStimulus(MD_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001,
                    1'b0, 1'b1, "t1_multu_max");
      for (int k = 1; k <= 35; k++) begin
         checkOutput($sformatf("t1_busy_c%0d", k), bus.busy, (k <= 33));
         checkOutput($sformatf("t1_done_c%0d", k), bus.done, (k == 34));
         if (k < 35) @(negedge clk);
      end

      // Test 2: signed multiply, then a back-to-back start in the DONE cycle.
      applyStimulus(MD_OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1,
                    1'b0, 1'b1, "t2_mult_neg3x5");
      waitDone("t2a");
      applyStimulus(MD_OP_MULT, 32'd7, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6,
                    1'b0, 1'b1, "t2_mult_7xneg6");
      waitDone("t2b");
      @(negedge clk);

      // Test 3: divides, including a start raised mid-CALC that must be ignored.
      applyStimulus(MD_OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD,
                    1'b0, 1'b1, "t3_div_neg7by2");
      waitDone("t3a");
      @(negedge clk);
      applyStimulus(MD_OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 1'b1, "t3_divu_7by2");
      repeat (4) @(negedge clk);
      bus.start = 1'b1; bus.op = MD_OP_MULTU; bus.operand_1 = 32'd9; bus.operand_2 = 32'd9;
      @(negedge clk);
      bus.start = 1'b0;
      waitDone("t3b");
      @(negedge clk);
      applyStimulus(MD_OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000,
                    1'b0, 1'b1, "t3_div_ovf");
      waitDone("t3c");
      @(negedge clk);
      applyStimulus(MD_OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD,
                    1'b0, 1'b1, "t3_div_7byneg2");
      waitDone("t3d");
      @(negedge clk);

      // Test 4: divide by zero, then a multiply that must clear div_by_zero.
      applyStimulus(MD_OP_DIVU, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF,
                    1'b1, 1'b1, "t4_divu_by0");
      waitDone("t4a");
      @(negedge clk);
      applyStimulus(MD_OP_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF,
                    1'b1, 1'b1, "t4_div_neg5by0");
      waitDone("t4b");
      @(negedge clk);
      applyStimulus(MD_OP_MULTU, 32'h00010000, 32'h00010000, 32'h1, 32'h0,
                    1'b0, 1'b1, "t4_multu_carry");
      waitDone("t4c");
      @(negedge clk);

      // Test 5: flush in CALC (ignored start at cycle 5, flush at cycle 10).
      applyStimulus(MD_OP_MULTU, 32'd3, 32'd4, 32'h0, 32'h0, 1'b0, 1'b0, "t5");
      repeat (4) @(negedge clk);
      bus.start = 1'b1; bus.op = MD_OP_DIVU; bus.operand_1 = 32'd50; bus.operand_2 = 32'd5;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      checkOutput("t5_flush_busy", bus.busy, 1'b0);
      checkOutput("t5_flush_done", bus.done, 1'b0);
      // flush together with start in IDLE: start must lose.
      bus.flush = 1'b1; bus.start = 1'b1; bus.op = MD_OP_MULTU;
      @(negedge clk);
      bus.flush = 1'b0; bus.start = 1'b0;
      checkOutput("t5_flush_vs_start_busy", bus.busy, 1'b0);
      repeat (40) @(negedge clk);
      checkOutput("t5_hold_hi", bus.hi, 32'h1);
      checkOutput("t5_hold_lo", bus.lo, 32'h0);
      checkOutput("t5_hold_dbz", bus.div_by_zero, 1'b0);

      // Flush landing on the FIX cycle must suppress the write and done.
      applyStimulus(MD_OP_MULTU, 32'd5, 32'd5, 32'h0, 32'h0, 1'b0, 1'b0, "t5b");
      repeat (32) @(negedge clk);
      checkOutput("t5b_in_fix_busy", bus.busy, 1'b1);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      checkOutput("t5b_flush_busy", bus.busy, 1'b0);
      repeat (5) @(negedge clk);
      checkOutput("t5b_hold_lo", bus.lo, 32'h0);
      checkOutput("t5b_hold_hi", bus.hi, 32'h1);

      // Test 6: async reset in the middle of a DIV, then a fresh DIVU.
      applyStimulus(MD_OP_DIV, 32'hFFFFFFF0, 32'd3, 32'h0, 32'h0, 1'b0, 1'b0, "t6");
      repeat (14) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 checkReset("t6_async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(MD_OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 1'b1, "t6_divu_9by3");
      waitDone("t6");
      @(negedge clk);

      // 8-bit instance: 0xFF x 0xFF unsigned, done 10 cycles after issue.
      bus8.start = 1'b1; bus8.op = MD_OP_MULTU;
      bus8.operand_1 = 8'hFF; bus8.operand_2 = 8'hFF;
      e8.hi = 32'hFE; e8.lo = 32'h01; e8.dbz = 1'b0; e8.issued = cyc; e8.tag = "t7_w8_multu";
      sb8.push_back(e8);
      @(negedge clk);
      bus8.start = 1'b0;
      k8 = 0;
      while (bus8.done !== 1'b1 && k8 < 50) begin
         @(negedge clk);
         k8++;
      end
      if (k8 >= 50) checkOutput("t7_timeout", bus8.done, 1'b1);
      repeat (3) @(negedge clk);

      checkOutput("sb_drained", sb.size(), 0);
      checkOutput("sb8_drained", sb8.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Multi-cycle integer multiply/divide unit for the EX stage, parametrised in WIDTH. It executes MULT, MULTU, DIV and DIVU and produces a 2*WIDTH result split into hi/lo. It sits beside the single-cycle adder. The pipeline stalls on busy and captures hi/lo on done.

Parameters:
WIDTH, 32, operand width in bits; hi/lo are each WIDTH bits.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when state is IDLE or DONE
op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
operand_1  input  WIDTH  multiplicand / dividend
operand_2  input  WIDTH  multiplier / divisor
flush  input  1  abort the operation in flight
busy  output  1  high while state is CALC or FIX
done  output  1  one-cycle pulse; hi/lo valid from this cycle
hi  output  WIDTH  product upper half / remainder
lo  output  WIDTH  product lower half / quotient
div_by_zero  output  1  valid with done; high when a DIV/DIVU had operand_2 == 0

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, hi=0, lo=0, div_by_zero=0; counter and datapath registers cleared. Reset during CALC/FIX abandons the operation.
- States: IDLE, CALC, FIX, DONE.
- Start accept:
  - In IDLE or DONE with start=1 and flush=0: latch op, sign flags and magnitudes.
    - Signed ops use abs(operand); unsigned ops use the raw value.
  - Clear counter; next state CALC.
  - start during CALC/FIX is ignored.
- CALC: one iteration per cycle for exactly WIDTH cycles (counter 0..WIDTH-1); at counter == WIDTH-1 go to FIX.
  - Multiply: shift-add over a 2*WIDTH accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring radix-2, one quotient bit per cycle, MSB first. Remainder register is WIDTH+1 bits so the trial subtract never overflows.
- FIX (1 cycle):
  - Apply sign correction.
    - MULT: negate the 2*WIDTH product if the operand signs differ.
    - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write hi/lo and div_by_zero; next state DONE.
- DONE (1 cycle): done=1; next state IDLE, or CALC if a new start is accepted in this cycle. hi/lo hold until the next FIX write.
- Latency: start sampled at edge 0 → done high in the cycle after edge WIDTH+1 (WIDTH+2 cycles). Throughput: one op per WIDTH+2 cycles back-to-back.
- Divide by zero (DIV or DIVU, operand_2 == 0): runs the full latency. Sign correction is bypassed: lo = all ones, hi = operand_1 as given, div_by_zero = 1.
- Signed overflow: DIV of most-negative by -1 gives lo = most-negative, hi = 0, div_by_zero = 0. No trap.
- Flush:
  - Any state except IDLE goes to IDLE next cycle; busy drops; done is not raised.
  - hi/lo/div_by_zero keep their previous values.
  - flush wins over a simultaneous start, and over FIX completing.
- MULTU/DIVU operands are treated as unsigned at all widths. Arithmetic wraps modulo 2^WIDTH per half.

Decomposition:
- Shared defines header (alongside the funct/bus defines): MD_OP_MULT/MULTU/DIV/DIVU 2-bit encodings, MD_STATE_* encodings, MD_WIDTH default.
- One sub-module, muldiv_negate: parametrised combinational conditional two's-complement negate, with an enable. Instantiated for operand abs (x2), product fix (2*WIDTH) and quotient/remainder fix.

Test Plan:
1. MULTU 0xFFFFFFFF × 0xFFFFFFFF, start at cycle 0 → done at cycle 34 only; hi=0xFFFFFFFE, lo=0x00000001; busy high cycles 1–33.
2. MULT -3 (0xFFFFFFFD) × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then a back-to-back start in the DONE cycle: MULT 7 × -6 → lo=0xFFFFFFD6, hi=0xFFFFFFFF, done 34 cycles later.
3. DIV -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7 / 2 → lo=3, hi=1. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
4. DIVU 100 / 0 → lo=0xFFFFFFFF, hi=0x00000064, div_by_zero=1. DIV -5 / 0 → lo=0xFFFFFFFF, hi=0xFFFFFFFB, div_by_zero=1.
5. Start MULTU 3 × 4, flush at cycle 10 → busy=0 at cycle 11, no done; hi/lo keep the prior result. A start asserted at cycle 5 (while busy) is ignored.
6. rst_n low at cycle 15 of a DIV → all outputs 0 immediately (async). After release, a fresh DIVU 9 / 3 gives lo=3, hi=0. Repeat test 1 with WIDTH=8: 0xFF×0xFF → hi=0xFE, lo=0x01, done at cycle 10.
